seg_scan_mux: RTL
=================

# seg_scan_mux

- 4-digit time-multiplexed 7-segment display driver.
- Sits directly downstream of the single-digit segment counter/decoder stage.
- Accepts a 4-digit BCD/hex value plus decimal-point mask over a valid/ready handshake, double-buffers it and scans it onto one shared segment bus with active-low digit enables.
- New values commit only at frame boundaries, so a displayed frame never mixes old and new digits.

## Interface
Parameters:
- SCAN_DIV, 4 — clk cycles each digit is driven; legal range ≥ 2; prescaler width = clog2(SCAN_DIV).

Ports:
- clk  in  1  — single system clock; all state on rising edge.
- rst  in  1  — reset, asynchronous, active-low (asserted when 0).
- upd_valid  in  1  — new display value offered.
- upd_ready  out  1  — block can accept a value; transfer when upd_valid & upd_ready on a rising edge.
- upd_bcd  in  16  — digit3..digit0, 4 bits each, digit0 = [3:0].
- upd_dp  in  4  — decimal point per digit, bit k = digit k, 1 = lit.
- seg  out  8  — {dp,g,f,e,d,c,b,a}, active-high.
- an  out  4  — digit enable, one-hot active-low, an[k] = digit k.
- frame_done  out  1  — one-cycle pulse at each frame start.

## Operation
- Registers:
  - prescaler `pc` (0..SCAN_DIV-1).
  - digit index `idx` (0..3).
  - display register `disp` (16b value + 4b dp).
  - pending register `pend` (same format).
  - state {IDLE, PEND}.
- Terminal count tc = (pc == SCAN_DIV-1). On tc: pc→0 and idx→idx+1 (3 wraps to 0). Otherwise pc→pc+1.
- Frame boundary fb = tc & (idx == 3).
- IDLE: upd_ready=1.
  - On upd_valid: capture upd_bcd/upd_dp into pend, go to PEND.
- PEND: upd_ready=0.
  - On fb: disp←pend, go to IDLE.
- Handshake and fb in the same cycle while IDLE: value goes to pend and commits at the following fb. It never goes to disp directly.
- seg/an are registered and computed from next-cycle idx and disp, so they change on the same edge as idx.
  - an = ~(1<<idx).
  - seg[6:0] = hex decode of the selected digit.
  - seg[7] = dp bit of the selected digit.
- Hex decode (gfedcba), 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- frame_done is registered: high for exactly the one cycle in which an first becomes 4'b1110 after a wrap.
- Reset (rst=0), applied immediately and asynchronously:
  - pc=0, idx=0, state=IDLE, disp=0, pend=0.
  - an=4'b1110, seg=8'h3F, upd_ready=1, frame_done=0.
- Reset mid-frame or mid-PEND: pending value discarded; scan restarts at digit0 on release.

## Timing
- Each digit is driven for exactly SCAN_DIV cycles. A frame is 4·SCAN_DIV cycles.
- After rst release, an sequence (SCAN_DIV=4):
  - 1110 for cycles 0-3.
  - 1101 for cycles 4-7.
  - 1011 for cycles 8-11.
  - 0111 for cycles 12-15.
  - 1110 from cycle 16, with frame_done=1 in cycle 16.
- Commit latency: from handshake edge to new digit0 on seg is at most one frame plus one cycle, i.e. ≤ 4·SCAN_DIV+1 cycles.
- upd_ready:
  - Low starting in the cycle after the accepting edge.
  - High again starting in the cycle after the committing fb edge.
- seg/an have no glitches: both are registered and change on the same edge.

## Configuration
- Macro LEADING_ZERO_BLANK_EN.
- When defined:
  - Digit k (k = 3, 2, 1) is blanked when disp digit k and every digit above it are 0.
  - A blanked digit drives seg[6:0]=0. Its seg[7] still follows dp and its an still follows the scan.
  - Digit0 is never blanked, so value 0 shows a single "0".
- When undefined: all four digits are always decoded; 0x0000 shows "0000".
- Handshake, timing and reset values are identical in both builds.

## Test plan
- Reset values: hold rst=0 → an=4'b1110, seg=8'h3F, upd_ready=1, frame_done=0. Release rst → an steps 1110/1101/1011/0111 every 4 cycles (SCAN_DIV=4), and frame_done pulses at cycle 16.
- Update commit: send upd_bcd=16'h1234, upd_dp=4'b0100 mid-frame.
  - Current frame remains all zeros.
  - Next frame shows, for digits 0..3 in order: seg=8'h66, 8'h4F, 8'hDB (0x5B with dp lit), 8'h06.
- Back-pressure: hold upd_valid=1 with 16'hAAAA, then 16'h5555 on the next cycle.
  - upd_ready drops after the first transfer.
  - 16'h5555 is accepted only after the next fb and appears one frame later.
  - 16'hAAAA is shown (seg=8'h77) for exactly one frame.
- Handshake coincident with fb: transfer 16'h00FF on the fb cycle → FF appears at the following frame boundary, not the current one.
- Blanking, with LEADING_ZERO_BLANK_EN:
  - 16'h0070 → digit3/digit2 seg=8'h00, digit1=8'h07, digit0=8'h3F.
  - Without the macro, digit3/digit2 show 8'h3F.
- Reset mid-operation: assert rst while in PEND at idx=2 → outputs return to reset values immediately, the pending value is never displayed, and upd_ready=1.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
// Update channel into seg_scan_mux: one 4-digit value plus dp mask over valid/ready.
interface seg_scan_mux_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_bcd;
    logic [3:0]  upd_dp;

    modport master (output upd_valid, output upd_bcd, output upd_dp, input upd_ready);
    modport slave  (input upd_valid, input upd_bcd, input upd_dp, output upd_ready);
endinterface

// File: rtl/seg_scan_mux.sv
// 4-digit time-multiplexed 7-segment driver; updates are double-buffered and commit only at frame boundaries.
// Build macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1 (digit0 always shown).
//
// state | meaning
// IDLE  | nothing pending, upd_ready high
// PEND  | value held in pend, copied to disp at the next frame boundary
module seg_scan_mux #(
    parameter int SCAN_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_mux_if.slave upd,
    output logic [7:0]    seg,
    output logic [3:0]    an,
    output logic          frame_done
);
    localparam int              PC_W    = $clog2(SCAN_DIV);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(SCAN_DIV - 1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     disp_bcd_q, disp_bcd_d;
    logic [3:0]      disp_dp_q, disp_dp_d;
    logic [15:0]     pend_bcd_q, pend_bcd_d;
    logic [3:0]      pend_dp_q, pend_dp_d;
    logic [7:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            frame_done_q, frame_done_d;
    logic            tc, fb, ready;
    logic [3:0]      nib;
    logic            blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        tc           = (pc_q == PC_LAST);
        pc_d         = tc ? '0 : pc_q + PC_W'(1);
        idx_d        = tc ? idx_q + 2'd1 : idx_q;
        fb           = tc && (idx_q == 2'd3);
        frame_done_d = fb;
    end

    always_comb begin
        state_d    = state_q;
        pend_bcd_d = pend_bcd_q;
        pend_dp_d  = pend_dp_q;
        disp_bcd_d = disp_bcd_q;
        disp_dp_d  = disp_dp_q;
        ready      = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                // A value accepted on a boundary edge still waits a full frame.
                if (upd.upd_valid) begin
                    pend_bcd_d = upd.upd_bcd;
                    pend_dp_d  = upd.upd_dp;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (fb) begin
                    disp_bcd_d = pend_bcd_q;
                    disp_dp_d  = pend_dp_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode from next-cycle idx/disp so seg and an update on the same edge.
    always_comb begin
        nib = disp_bcd_d[4*idx_d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_d)
            2'd3:    blank = (disp_bcd_d[15:12] == 4'h0);
            2'd2:    blank = (disp_bcd_d[15:8] == 8'h00);
            2'd1:    blank = (disp_bcd_d[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
        seg_d = {disp_dp_d[idx_d], blank ? 7'h00 : hex7(nib)};
        an_d  = ~(4'b0001 << idx_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            idx_q        <= 2'd0;
            disp_bcd_q   <= 16'h0000;
            disp_dp_q    <= 4'h0;
            pend_bcd_q   <= 16'h0000;
            pend_dp_q    <= 4'h0;
            seg_q        <= 8'h3F;
            an_q         <= 4'b1110;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_dp_q    <= disp_dp_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_dp_q    <= pend_dp_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign upd.upd_ready = ready;
    assign seg           = seg_q;
    assign an            = an_q;
    assign frame_done    = frame_done_q;
endmodule
